elevator_ctrl_n: RTL and testbench

- Parametrised N-floor elevator controller: latches per-floor call requests, runs a timed door phase and a safety check, and moves the car floor by floor under SCAN (collective) scheduling.
- Sits between floor call buttons / safety sensors and the motor/brake/door drivers.
- A system-level tick (e.g. 1 Hz from the clock divider) paces all timing.
- Adds over the previous controller: floor tracking, direction selection, programmable door/travel times, and a latched FAULT state after repeated safety failures.

---
 rtl/elevator_ctrl_n.sv | 161 ++++++++++++++++
 tb/tb_elevator_ctrl_n.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: latches floor calls, runs a timed door phase and
// a safety check, and moves the car one floor at a time under SCAN scheduling.
module elevator_ctrl_n #(
  parameter int unsigned NUM_FLOORS  = 5,
  parameter int unsigned FLOOR_W     = 3,
  parameter int unsigned DOOR_TICKS  = 10,
  parameter int unsigned MOVE_TICKS  = 4,
  parameter int unsigned RETRY_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  overweight,
  input  logic                  jammed_door,
  output logic [2:0]            state,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  motor,
  output logic                  brake,
  output logic                  open_door,
  output logic                  alarm
);

  localparam int unsigned MAX_TICKS = (DOOR_TICKS > MOVE_TICKS) ? DOOR_TICKS : MOVE_TICKS;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
  localparam int unsigned RETRY_W   = $clog2(RETRY_LIMIT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DOOR  = 3'd1,
    ST_CHECK = 3'd2,
    ST_MOVE  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  state_e               st;
  logic [CNT_W-1:0]     door_cnt;
  logic [CNT_W-1:0]     move_cnt;
  logic [RETRY_W-1:0]   retry;

  logic [NUM_FLOORS-1:0] p_any, cur_oh, mv_oh, above_mask, below_mask;
  logic [FLOOR_W-1:0]    floor_mv;
  logic                  any_above, any_below, safety_bad, req_here;
  logic [RETRY_W-1:0]    retry_inc;

  assign state = st;

  // Request view, floor masks and the floor the car would reach next
  always_comb begin
    p_any    = pending | req;
    floor_mv = floor;
    if (dir_up && floor != FLOOR_W'(NUM_FLOORS - 1)) floor_mv = floor + FLOOR_W'(1);
    if (!dir_up && floor != '0)                      floor_mv = floor - FLOOR_W'(1);
    cur_oh     = '0;
    mv_oh      = '0;
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      cur_oh[i]     = (FLOOR_W'(i) == floor);
      mv_oh[i]      = (FLOOR_W'(i) == floor_mv);
      above_mask[i] = (FLOOR_W'(i) > floor);
      below_mask[i] = (FLOOR_W'(i) < floor);
    end
    any_above  = |(p_any & above_mask);
    any_below  = |(p_any & below_mask);
    safety_bad = overweight | jammed_door;
    req_here   = |(req & cur_oh);
    retry_inc  = retry + RETRY_W'(1);
  end

  // Controller FSM; outputs are updated on every transition edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= ST_IDLE;
      floor     <= '0;
      dir_up    <= 1'b1;
      pending   <= '0;
      door_cnt  <= '0;
      move_cnt  <= '0;
      retry     <= '0;
      motor     <= 1'b0;
      brake     <= 1'b1;
      open_door <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      pending <= p_any;
      case (st)
        ST_IDLE: begin
          if (|(p_any & cur_oh)) begin
            st        <= ST_DOOR;
            door_cnt  <= CNT_W'(DOOR_TICKS);
            open_door <= 1'b1;
            pending   <= p_any & ~cur_oh;
          end else if (|p_any) begin
            st     <= ST_CHECK;
            dir_up <= any_above;
          end
        end
        ST_DOOR: begin
          pending <= p_any & ~cur_oh;
          if (safety_bad || req_here) begin
            door_cnt <= CNT_W'(DOOR_TICKS);
          end else if (tick) begin
            door_cnt <= door_cnt - CNT_W'(1);
            if (door_cnt == CNT_W'(1)) begin
              open_door <= 1'b0;
              st        <= (|(p_any & ~cur_oh)) ? ST_CHECK : ST_IDLE;
            end
          end
        end
        ST_CHECK: begin
          if (safety_bad) begin
            retry     <= retry_inc;
            open_door <= 1'b1;
            if (retry_inc >= RETRY_W'(RETRY_LIMIT)) begin
              st    <= ST_FAULT;
              alarm <= 1'b1;
            end else begin
              st       <= ST_DOOR;
              door_cnt <= CNT_W'(DOOR_TICKS);
              pending  <= p_any & ~cur_oh;
            end
          end else if (any_above || any_below) begin
            // keep heading while work lies ahead, otherwise reverse
            dir_up   <= dir_up ? any_above : ~any_below;
            st       <= ST_MOVE;
            move_cnt <= CNT_W'(MOVE_TICKS);
            retry    <= '0;
            motor    <= 1'b1;
            brake    <= 1'b0;
          end else begin
            st <= ST_IDLE;
          end
        end
        ST_MOVE: begin
          if (tick) begin
            move_cnt <= move_cnt - CNT_W'(1);
            if (move_cnt == CNT_W'(1)) begin
              floor <= floor_mv;
              if (|(p_any & mv_oh)) begin
                st        <= ST_DOOR;
                door_cnt  <= CNT_W'(DOOR_TICKS);
                pending   <= p_any & ~mv_oh;
                motor     <= 1'b0;
                brake     <= 1'b1;
                open_door <= 1'b1;
              end else begin
                move_cnt <= CNT_W'(MOVE_TICKS);
              end
            end
          end
        end
        ST_FAULT: ;
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Bench for elevator_ctrl_n: directed scenarios plus random traffic, every cycle
// compared against a tick-level behavioural model of the car.
module tb_elevator_ctrl_n;

  localparam int NF = 5;
  localparam int FW = 3;
  localparam int DOOR_T = 10;
  localparam int MOVE_T = 4;
  localparam int RETRY = 3;
  localparam int S_IDLE = 0, S_DOOR = 1, S_CHECK = 2, S_MOVE = 3, S_FAULT = 4;

  logic          clk;
  logic          reset;
  logic          tick;
  logic [NF-1:0] req;
  logic          overweight, jammed_door;
  logic [2:0]    state;
  logic [FW-1:0] floor;
  logic          dir_up;
  logic [NF-1:0] pending;
  logic          motor, brake, open_door, alarm;

  int checks = 0;
  int errors = 0;

  int          m_st, m_floor, m_door, m_move, m_retry;
  bit          m_dir;
  bit [NF-1:0] m_pend;

  elevator_ctrl_n #(.NUM_FLOORS(NF), .FLOOR_W(FW), .DOOR_TICKS(DOOR_T),
                    .MOVE_TICKS(MOVE_T), .RETRY_LIMIT(RETRY)) dut (
    .clk(clk), .reset(reset), .tick(tick), .req(req), .overweight(overweight),
    .jammed_door(jammed_door), .state(state), .floor(floor), .dir_up(dir_up),
    .pending(pending), .motor(motor), .brake(brake), .open_door(open_door), .alarm(alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    if (errors >= 30) finish_run();
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_floor = 0; m_dir = 1'b1; m_pend = '0;
    m_door = 0; m_move = 0; m_retry = 0;
  endtask

  // One clock of the car, from the written rules
  task automatic model_step(input bit [NF-1:0] r, input bit t, input bit bad);
    bit [NF-1:0] want;
    int nabove, nbelow, ahead, behind;
    bit was_door;
    want = m_pend | r;
    nabove = 0; nbelow = 0;
    for (int f = 0; f < NF; f++)
      if (want[f]) begin
        if (f > m_floor) nabove++;
        else if (f < m_floor) nbelow++;
      end
    was_door = (m_st == S_DOOR);
    m_pend = want;
    case (m_st)
      S_IDLE:
        if (want[m_floor]) begin m_st = S_DOOR; m_door = DOOR_T; end
        else if (want != 0) begin m_dir = (nabove > 0); m_st = S_CHECK; end
      S_DOOR:
        if (bad || r[m_floor]) m_door = DOOR_T;
        else if (t) begin
          m_door--;
          if (m_door == 0) begin
            want[m_floor] = 1'b0;
            m_st = (want != 0) ? S_CHECK : S_IDLE;
          end
        end
      S_CHECK:
        if (bad) begin
          m_retry++;
          if (m_retry >= RETRY) m_st = S_FAULT;
          else begin m_st = S_DOOR; m_door = DOOR_T; end
        end else begin
          ahead  = m_dir ? nabove : nbelow;
          behind = m_dir ? nbelow : nabove;
          if (ahead > 0 || behind > 0) begin
            if (ahead == 0) m_dir = !m_dir;
            m_st = S_MOVE; m_move = MOVE_T; m_retry = 0;
          end else m_st = S_IDLE;
        end
      S_MOVE:
        if (t) begin
          m_move--;
          if (m_move == 0) begin
            m_floor = m_dir ? m_floor + 1 : m_floor - 1;
            if (want[m_floor]) begin m_st = S_DOOR; m_door = DOOR_T; end
            else m_move = MOVE_T;
          end
        end
      default: ;
    endcase
    if (was_door || m_st == S_DOOR) m_pend[m_floor] = 1'b0;
  endtask

  task automatic compare_all();
    bit ok;
    chk("state", 32'(state), 32'(m_st));
    chk("floor", 32'(floor), 32'(m_floor));
    chk("dir_up", 32'(dir_up), 32'(m_dir));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("drive", 32'({motor, brake, open_door, alarm}),
        32'({m_st == S_MOVE, m_st != S_MOVE, m_st == S_DOOR || m_st == S_FAULT, m_st == S_FAULT}));
    if (state == 3'd3) begin
      ok = 1'b0;
      for (int f = 0; f < NF; f++)
        if (pending[f] && (dir_up ? (f > int'(floor)) : (f < int'(floor)))) ok = 1'b1;
      chk("target_ahead", 32'(ok), 32'd1);
    end
  endtask

  task automatic step(input bit t);
    tick = t;
    @(posedge clk);
    model_step(req, t, overweight | jammed_door);
    #1;
    compare_all();
    req = '0;
    tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1); step(1'b0); step(1'b0); step(1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    #4 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; req = '0; overweight = 1'b0; jammed_door = 1'b0;
    model_reset();
    do_reset();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_brake", 32'({motor, brake, open_door, alarm}), 32'b0100);
    chk("rst_dir", 32'(dir_up), 32'd1);

    // Single call to floor 3 from floor 0
    req = 5'b01000; step(1'b0);
    chk("s1_check", 32'(state), 32'd2);
    chk("s1_dir", 32'(dir_up), 32'd1);
    step(1'b0);
    chk("s1_move", 32'(state), 32'd3);
    run_ticks(12);
    chk("s1_floor", 32'(floor), 32'd3);
    chk("s1_door", 32'(state), 32'd1);
    chk("s1_clr", 32'(pending), 32'd0);
    run_ticks(9);
    chk("s1_still_open", 32'(open_door), 32'd1);
    run_ticks(1);
    chk("s1_idle", 32'(state), 32'd0);

    // Collective stops on the way up, then reversal down to floor 0
    do_reset();
    req = 5'b10000; step(1'b0); step(1'b0);
    run_ticks(8);
    chk("s2_at2", 32'(floor), 32'd2);
    req = 5'b01001; step(1'b0);
    chk("s2_pend", 32'(pending), 32'b11001);
    run_ticks(4);
    chk("s2_stop3", 32'({floor, state}), 32'({3'd3, 3'd1}));
    run_ticks(10);
    run_ticks(4);
    chk("s2_stop4", 32'({floor, state}), 32'({3'd4, 3'd1}));
    run_ticks(10);
    chk("s2_reverse", 32'({dir_up, state}), 32'({1'b0, 3'd3}));
    run_ticks(16);
    chk("s2_stop0", 32'({floor, state}), 32'({3'd0, 3'd1}));
    run_ticks(10);
    chk("s2_done", 32'({pending, state}), 32'({5'b00000, 3'd0}));

    // Three failed safety checks latch FAULT
    do_reset();
    req = 5'b00100; step(1'b0);
    for (int n = 0; n < RETRY; n++) begin
      overweight = 1'b1; step(1'b0); overweight = 1'b0;
      if (n < RETRY - 1) begin
        chk("s3_retry_door", 32'(state), 32'd1);
        run_ticks(9); step(1'b1);
      end
    end
    chk("s3_fault", 32'({state, alarm, motor, brake, open_door}), 32'({3'd4, 4'b1011}));
    req = 5'b00001; run_ticks(5);
    chk("s3_stays", 32'(state), 32'd4);
    chk("s3_latch", 32'(pending), 32'b00101);

    // Door jam reloads the door timer; one failed check does not fault
    do_reset();
    req = 5'b00011; step(1'b0);
    run_ticks(7);
    jammed_door = 1'b1; step(1'b1); jammed_door = 1'b0;
    step(1'b0); step(1'b0); step(1'b0);
    run_ticks(9);
    chk("s4_reloaded", 32'(state), 32'd1);
    step(1'b1);
    chk("s4_check", 32'(state), 32'd2);
    jammed_door = 1'b1; step(1'b0); jammed_door = 1'b0;
    chk("s4_nofault", 32'(state), 32'd1);
    run_ticks(9); step(1'b1); step(1'b0);
    chk("s4_move", 32'(state), 32'd3);
    run_ticks(4);
    chk("s4_floor1", 32'({floor, state}), 32'({3'd1, 3'd1}));

    // Hall call at the open floor restarts the door and never latches
    run_ticks(5);
    req = 5'b00010; step(1'b0);
    chk("s5_nolatch", 32'(pending), 32'd0);
    run_ticks(9);
    chk("s5_open", 32'(state), 32'd1);
    run_ticks(1);
    chk("s5_idle", 32'(state), 32'd0);

    // Asynchronous reset in the middle of a move
    do_reset();
    req = 5'b10000; step(1'b0); step(1'b0);
    run_ticks(6);
    chk("s6_moving", 32'({floor, state}), 32'({3'd1, 3'd3}));
    #2 reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("s6_async", 32'({state, floor, motor, brake}), 32'({3'd0, 3'd0, 2'b01}));
    #2 reset = 1'b1;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (($urandom % 16) == 0) req = NF'(32'd1 << ($urandom % NF));
      overweight  = (($urandom % 48) == 0);
      jammed_door = (($urandom % 48) == 0);
      if ((c % 700) == 699) do_reset();
      else step(1'($urandom % 2));
    end
    overweight = 1'b0; jammed_door = 1'b0;
    finish_run();
  end

endmodule
